// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: requester-side controller for the 8-bit registered ALU.
// Takes one operation at a time on a valid/ready request port. It issues the
// operation to the ALU with a single-cycle alu_start and waits ALU_LATENCY
// cycles. It then captures alu_result and presents it on a valid/ready
// response port. Only one operation is in flight, and there is no reordering.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_a/req_b/req_op          request operands and opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
//   alu_start                   one-cycle ALU enable
//   alu_a/alu_b/alu_opcode      operands/opcode held towards the ALU
//   alu_result                  ALU result, valid ALU_LATENCY cycles after alu_start
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_op             captured result and its opcode
//   busy                        high whenever the sequencer is not idle
//   op_count                    number of handed-off responses (wraps)
module alu_op_sequencer #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ALU_LATENCY = 1,   // legal range 1..15
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [1:0]        req_op,
   output logic              alu_start,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_op,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   localparam int unsigned WAIT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              ready_q;
   logic              accept_c;
   logic              wait_done_c;
   logic              rsp_done_c;

   // ready_q resets high. Gating it with rst_n keeps req_ready low while reset
   // is asserted and lets it rise as soon as reset is released.
   assign req_ready   = ready_q & rst_n;
   assign accept_c    = req_valid & req_ready;
   assign wait_done_c = (state == S_WAIT) && (wait_cnt == '0);
   assign rsp_done_c  = (state == S_RESP) && rsp_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept_c)    state_nxt = S_ISSUE;
         S_ISSUE:                  state_nxt = S_WAIT;
         S_WAIT:  if (wait_done_c) state_nxt = S_RESP;
         S_RESP:  if (rsp_done_c)  state_nxt = S_IDLE;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so that they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b1;
         alu_start <= 1'b0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         ready_q   <= (state_nxt == S_IDLE);
         alu_start <= (state_nxt == S_ISSUE);
         busy      <= (state_nxt != S_IDLE);
         rsp_valid <= (state_nxt == S_RESP);
      end
   end

   // Operand latch: changes only when a request is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= 2'b00;
      end else if (accept_c) begin
         alu_a      <= req_a;
         alu_b      <= req_b;
         alu_opcode <= req_op;
      end
   end

   // Latency counter: loaded in ISSUE and counts down to zero during WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == S_ISSUE) begin
         wait_cnt <= WAIT_W'(ALU_LATENCY - 1);
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
         wait_cnt <= wait_cnt - WAIT_W'(1);
      end
   end

   // Response capture: holds until the next capture, including after the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_op   <= 2'b00;
      end else if (wait_done_c) begin
         rsp_data <= alu_result;
         rsp_op   <= alu_opcode;
      end
   end

   // Completed-operation counter: wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (rsp_done_c) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. It builds two instances: one with ALU_LATENCY=1
// and a 16-bit counter, and one with ALU_LATENCY=3 and a 4-bit counter. A
// behavioural ALU pipeline feeds each instance. Every response is compared
// with an arithmetic reference.
module tb_alu_op_sequencer;

   localparam int unsigned DW   = 8;
   localparam int unsigned LAT0 = 1;
   localparam int unsigned LAT1 = 3;
   localparam int unsigned CW0  = 16;
   localparam int unsigned CW1  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          req_valid  [2];
   logic          req_ready  [2];
   logic [DW-1:0] req_a      [2];
   logic [DW-1:0] req_b      [2];
   logic [1:0]    req_op     [2];
   logic          alu_start  [2];
   logic [DW-1:0] alu_a      [2];
   logic [DW-1:0] alu_b      [2];
   logic [1:0]    alu_opcode [2];
   logic [DW-1:0] alu_result [2];
   logic          rsp_valid  [2];
   logic          rsp_ready  [2];
   logic [DW-1:0] rsp_data   [2];
   logic [1:0]    rsp_op     [2];
   logic          busy       [2];
   logic [CW0-1:0] op_count0;
   logic [CW1-1:0] op_count1;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned exp_count [2];

   alu_op_sequencer #(.DATA_W(DW), .ALU_LATENCY(LAT0), .CNT_W(CW0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
      .alu_start(alu_start[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
      .alu_opcode(alu_opcode[0]), .alu_result(alu_result[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_op(rsp_op[0]),
      .busy(busy[0]), .op_count(op_count0)
   );

   alu_op_sequencer #(.DATA_W(DW), .ALU_LATENCY(LAT1), .CNT_W(CW1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
      .alu_start(alu_start[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
      .alu_opcode(alu_opcode[1]), .alu_result(alu_result[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_op(rsp_op[1]),
      .busy(busy[1]), .op_count(op_count1)
   );

   function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] op);
      case (op)
         2'b00:   return DW'(a + b);
         2'b01:   return DW'(a - b);
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // ALU model: the result appears LAT cycles after the alu_start edge; random junk otherwise
   logic [DW-1:0] pipe [2][16];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         pipe[k][0] <= alu_start[k] ? alu_ref(alu_a[k], alu_b[k], alu_opcode[k]) : DW'($urandom);
         for (int i = 1; i < 16; i++) pipe[k][i] <= pipe[k][i-1];
      end
   end
   assign alu_result[0] = pipe[0][LAT0-1];
   assign alu_result[1] = pipe[1][LAT1-1];

   function automatic logic [31:0] count_of(input int k);
      return (k == 0) ? 32'(op_count0) : 32'(op_count1);
   endfunction

   function automatic int unsigned cnt_mask(input int k);
      return (k == 0) ? 32'h0000_FFFF : 32'h0000_000F;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? int'(LAT0) : int'(LAT1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Runs one full operation on instance k. Call at a negedge. stall = rsp_ready-low cycles
   // in RESP. poke = hold a bogus request during the operation, which must be ignored.
   task automatic run_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op, input int stall, input bit poke);
      int          j;
      int          starts;
      bit          ready_seen;
      bit          busy_low;
      logic [DW-1:0] exp_d;
      logic [31:0] cnt_before;
      exp_d        = alu_ref(a, b, op);
      rsp_ready[k] = (stall == 0);
      req_a[k]     = a;
      req_b[k]     = b;
      req_op[k]    = op;
      req_valid[k] = 1'b1;
      j = 0;
      while (!req_ready[k] && j < 50) begin
         @(negedge clk);
         j++;
      end
      if (!req_ready[k]) check("req_ready_timeout", 32'(req_ready[k]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid[k] = 1'b0;
      if (poke) begin
         req_valid[k] = 1'b1;
         req_a[k]     = ~a;
         req_b[k]     = ~b;
         req_op[k]    = ~op;
      end
      cnt_before = count_of(k);
      starts     = 0;
      ready_seen = 1'b0;
      busy_low   = 1'b0;
      j          = 0;
      while (!rsp_valid[k] && j < 40) begin
         starts     += 32'(alu_start[k]);
         ready_seen |= req_ready[k];
         busy_low   |= !busy[k];
         @(negedge clk);
         j++;
      end
      req_valid[k] = 1'b0;
      check("rsp_latency", 32'(j), 32'(1 + lat_of(k)));
      check("start_pulses", 32'(starts), 32'd1);
      check("ready_while_busy", 32'(ready_seen), 32'd0);
      check("busy_dropped", 32'(busy_low), 32'd0);
      check("alu_a_held", 32'(alu_a[k]), 32'(a));
      check("alu_b_held", 32'(alu_b[k]), 32'(b));
      check("alu_opcode_held", 32'(alu_opcode[k]), 32'(op));
      check("rsp_data", 32'(rsp_data[k]), 32'(exp_d));
      check("rsp_op", 32'(rsp_op[k]), 32'(op));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid[k]), 32'd1);
         check("bp_rsp_data", 32'(rsp_data[k]), 32'(exp_d));
         check("bp_op_count", count_of(k), cnt_before);
      end
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      exp_count[k] = (exp_count[k] + 1) & cnt_mask(k);
      check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("op_count", count_of(k), 32'(exp_count[k]));
      check("post_req_ready", 32'(req_ready[k]), 32'd1);
      check("post_busy", 32'(busy[k]), 32'd0);
      check("rsp_data_hold", 32'(rsp_data[k]), 32'(exp_d));
      rsp_ready[k] = 1'($urandom_range(0, 1));
   endtask

   task automatic check_all_zero(input int k, input string tag);
      check({tag, "_req_ready"}, 32'(req_ready[k]), 32'd0);
      check({tag, "_alu_start"}, 32'(alu_start[k]), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
      check({tag, "_busy"}, 32'(busy[k]), 32'd0);
      check({tag, "_alu_a"}, 32'(alu_a[k]), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data[k]), 32'd0);
      check({tag, "_op_count"}, count_of(k), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         req_a[k]     = '0;
         req_b[k]     = '0;
         req_op[k]    = 2'b00;
         rsp_ready[k] = 1'b0;
         exp_count[k] = 0;
      end
      #1 rst_n = 1'b0;
      #1;
      check_all_zero(0, "reset0");
      check_all_zero(1, "reset1");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_req_ready0", 32'(req_ready[0]), 32'd1);
      check("release_req_ready1", 32'(req_ready[1]), 32'd1);
      @(negedge clk);

      // T1 single ADD
      run_op(0, 8'h02, 8'h04, 2'b00, 0, 1'b0);
      // T2 back-to-back SUB then AND; a bogus request is held during the SUB
      run_op(0, 8'h0A, 8'h04, 2'b01, 0, 1'b1);
      run_op(0, 8'h1A, 8'h1E, 2'b10, 0, 1'b0);
      // T3 response backpressure
      run_op(0, 8'h1A, 8'h1E, 2'b11, 5, 1'b0);
      // T4 latency 3, 8-bit wrap
      run_op(1, 8'hFF, 8'h01, 2'b00, 0, 1'b0);

      // T5 reset during WAIT
      rsp_ready[0] = 1'b1;
      req_a[0]     = 8'h33;
      req_b[0]     = 8'h44;
      req_op[0]    = 2'b00;
      req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("t5_in_wait_busy", 32'(busy[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero(0, "midop");
      exp_count[0] = 0;
      exp_count[1] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(rsp_valid[0]), 32'd0);
      end
      run_op(0, 8'h01, 8'h01, 2'b00, 0, 1'b0);

      // T6 4-bit counter wraps after 16 completions
      for (int i = 0; i < 16; i++)
         run_op(1, DW'($urandom), DW'($urandom), 2'($urandom), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
      check("count_wrap", count_of(1), 32'd0);

      // Random traffic on both instances
      for (int i = 0; i < 40; i++)
         run_op($urandom_range(0, 1), DW'($urandom), DW'($urandom), 2'($urandom),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
